// File: rtl/curve_config_unit_pkg.sv
// Shared widths and payload types for the curve parameter store and its
// Barrett constant engine.
package curve_config_unit_pkg;

  localparam int unsigned P_WIDTH = 256;
  localparam int unsigned K_W     = $clog2(P_WIDTH + 1);
  localparam int unsigned MU_W    = P_WIDTH + 2;
  localparam int unsigned CNT_W   = K_W + 1;

  typedef struct packed {
    logic [P_WIDTH-1:0] x;
    logic [P_WIDTH-1:0] y;
  } curve_point_t;

  typedef struct packed {
    logic [P_WIDTH-1:0] p;
    logic [P_WIDTH-1:0] n;
    logic [P_WIDTH-1:0] a;
    logic [P_WIDTH-1:0] b;
    curve_point_t       g;
  } curve_parameters_t;

  typedef struct packed {
    logic [MU_W-1:0] mu;
    logic [K_W-1:0]  k;
  } barrett_params_t;

  typedef enum logic [2:0] {
    FIELD_P  = 3'd0,
    FIELD_N  = 3'd1,
    FIELD_A  = 3'd2,
    FIELD_B  = 3'd3,
    FIELD_GX = 3'd4,
    FIELD_GY = 3'd5
  } curve_field_e;

  // Priority encoder: index of the most significant set bit plus one (0 for v == 0).
  function automatic logic [K_W-1:0] bit_length(input logic [P_WIDTH-1:0] v);
    logic [K_W-1:0] len;
    len = '0;
    for (int unsigned i = 0; i < P_WIDTH; i++) begin
      if (v[i]) len = K_W'(i + 1);
    end
    return len;
  endfunction

endpackage

// File: rtl/barrett_mu_divider.sv
// Restoring shift-subtract divider producing mu = floor(2^(2k) / p),
// one quotient bit per cycle, MSB first, 2k+1 cycles after start.
module barrett_mu_divider
  import curve_config_unit_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [P_WIDTH-1:0] p,
  input  logic [K_W-1:0]     k,
  output logic               done_c,
  output logic [MU_W-1:0]    mu
);

  localparam int unsigned REM_W = P_WIDTH + 1;

  logic               active_q, active_d;
  logic               first_q, first_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [MU_W-1:0]    quo_q, quo_d;
  logic [REM_W:0]     rem_shift_c;
  logic               ge_c;

  // The dividend 2^(2k) has a single 1 at its top bit, so only the first step shifts in a 1.
  always_comb begin
    active_d    = active_q;
    first_d     = first_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    rem_shift_c = {rem_q, first_q};
    ge_c        = rem_shift_c >= {2'b00, p};
    if (start) begin
      active_d = 1'b1;
      first_d  = 1'b1;
      cnt_d    = {k, 1'b1};
      rem_d    = '0;
      quo_d    = '0;
    end else if (active_q) begin
      rem_d   = ge_c ? REM_W'(rem_shift_c - {2'b00, p}) : rem_shift_c[REM_W-1:0];
      quo_d   = {quo_q[MU_W-2:0], ge_c};
      first_d = 1'b0;
      cnt_d   = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      first_q  <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
    end else begin
      active_q <= active_d;
      first_q  <= first_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
    end
  end

  assign done_c = active_q && (cnt_q == CNT_W'(1));
  assign mu     = quo_q;

endmodule

// File: rtl/curve_config_unit.sv
// Runtime-programmable elliptic-curve parameter slots with per-slot Barrett
// constants computed on commit; presents the selected slot to the datapath.
module curve_config_unit
  import curve_config_unit_pkg::*;
#(
  parameter  int unsigned NUM_CURVES = 4,
  localparam int unsigned ID_W       = (NUM_CURVES > 1) ? $clog2(NUM_CURVES) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [ID_W-1:0]    wr_id,
  input  logic [2:0]         wr_field,
  input  logic [P_WIDTH-1:0] wr_data,
  output logic               wr_err,
  input  logic               commit_valid,
  input  logic [ID_W-1:0]    commit_id,
  output logic               commit_ready,
  input  logic [ID_W-1:0]    sel_id,
  output logic               busy,
  output curve_parameters_t  params_out,
  output logic [MU_W-1:0]    mu_out,
  output logic [K_W-1:0]     k_out,
  output logic               cfg_valid,
  output logic               commit_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DIV, ST_DONE} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    work_id_q, work_id_d;
  logic [P_WIDTH-1:0] work_p_q, work_p_d;
  logic [K_W-1:0]     work_k_q, work_k_d;

  curve_parameters_t  slot_par_q [NUM_CURVES];
  curve_parameters_t  slot_par_d [NUM_CURVES];
  barrett_params_t    slot_bar_q [NUM_CURVES];
  barrett_params_t    slot_bar_d [NUM_CURVES];
  logic [NUM_CURVES-1:0] slot_vld_q, slot_vld_d;

  logic busy_q, busy_d;
  logic commit_ready_q, commit_ready_d;
  logic wr_err_q, wr_err_d;
  logic commit_err_q, commit_err_d;
  curve_parameters_t params_q, params_d;
  barrett_params_t   bar_out_q, bar_out_d;
  logic cfg_valid_q, cfg_valid_d;

  logic [K_W-1:0]     scan_k_c;
  logic [P_WIDTH-1:0] commit_p_c;
  logic               wr_block_c;
  logic               wr_field_ok_c;
  logic               div_start_c;
  logic               div_done_c;
  logic [MU_W-1:0]    div_mu;

  barrett_mu_divider u_div (
    .clk    (clk),
    .reset  (reset),
    .start  (div_start_c),
    .p      (work_p_q),
    .k      (scan_k_c),
    .done_c (div_done_c),
    .mu     (div_mu)
  );

  always_comb begin
    state_d      = state_q;
    work_id_d    = work_id_q;
    work_p_d     = work_p_q;
    work_k_d     = work_k_q;
    slot_par_d   = slot_par_q;
    slot_bar_d   = slot_bar_q;
    slot_vld_d   = slot_vld_q;
    commit_err_d = 1'b0;
    div_start_c  = 1'b0;
    commit_p_c   = '0;
    params_d     = '0;
    bar_out_d    = '0;
    cfg_valid_d  = 1'b0;
    scan_k_c      = bit_length(work_p_q);
    wr_field_ok_c = (wr_field <= FIELD_GY);
    wr_block_c    = busy_q && (wr_id == work_id_q);
    wr_err_d      = wr_en && wr_block_c;

    // Field writes; the slot under computation is locked until it returns to IDLE
    for (int unsigned i = 0; i < NUM_CURVES; i++) begin
      if (wr_en && !wr_block_c && wr_field_ok_c && (wr_id == ID_W'(i))) begin
        case (wr_field)
          FIELD_P:  slot_par_d[i].p   = wr_data;
          FIELD_N:  slot_par_d[i].n   = wr_data;
          FIELD_A:  slot_par_d[i].a   = wr_data;
          FIELD_B:  slot_par_d[i].b   = wr_data;
          FIELD_GX: slot_par_d[i].g.x = wr_data;
          FIELD_GY: slot_par_d[i].g.y = wr_data;
          default:  ;
        endcase
        slot_vld_d[i] = 1'b0;
      end
      if (commit_id == ID_W'(i)) commit_p_c = slot_par_q[i].p;
    end

    case (state_q)
      ST_IDLE: begin
        if (commit_valid && commit_ready_q) begin
          work_id_d = commit_id;
          work_p_d  = commit_p_c;
          state_d   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (work_p_q < P_WIDTH'(2)) begin
          commit_err_d = 1'b1;
          state_d      = ST_IDLE;
          for (int unsigned i = 0; i < NUM_CURVES; i++) begin
            if (work_id_q == ID_W'(i)) slot_vld_d[i] = 1'b0;
          end
        end else begin
          work_k_d    = scan_k_c;
          div_start_c = 1'b1;
          state_d     = ST_DIV;
        end
      end
      ST_DIV: begin
        if (div_done_c) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        for (int unsigned i = 0; i < NUM_CURVES; i++) begin
          if (work_id_q == ID_W'(i)) begin
            slot_bar_d[i].mu = div_mu;
            slot_bar_d[i].k  = work_k_q;
            slot_vld_d[i]    = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d         = (state_d != ST_IDLE);
    commit_ready_d = (state_d == ST_IDLE);

    // Registered view of the selected slot
    for (int unsigned i = 0; i < NUM_CURVES; i++) begin
      if (sel_id == ID_W'(i)) begin
        params_d    = slot_par_q[i];
        bar_out_d   = slot_bar_q[i];
        cfg_valid_d = slot_vld_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      work_id_q      <= '0;
      work_p_q       <= '0;
      work_k_q       <= '0;
      for (int unsigned i = 0; i < NUM_CURVES; i++) begin
        slot_par_q[i] <= '0;
        slot_bar_q[i] <= '0;
      end
      slot_vld_q     <= '0;
      busy_q         <= 1'b0;
      commit_ready_q <= 1'b1;
      wr_err_q       <= 1'b0;
      commit_err_q   <= 1'b0;
      params_q       <= '0;
      bar_out_q      <= '0;
      cfg_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      work_id_q      <= work_id_d;
      work_p_q       <= work_p_d;
      work_k_q       <= work_k_d;
      slot_par_q     <= slot_par_d;
      slot_bar_q     <= slot_bar_d;
      slot_vld_q     <= slot_vld_d;
      busy_q         <= busy_d;
      commit_ready_q <= commit_ready_d;
      wr_err_q       <= wr_err_d;
      commit_err_q   <= commit_err_d;
      params_q       <= params_d;
      bar_out_q      <= bar_out_d;
      cfg_valid_q    <= cfg_valid_d;
    end
  end

  assign busy         = busy_q;
  assign commit_ready = commit_ready_q;
  assign wr_err       = wr_err_q;
  assign commit_err   = commit_err_q;
  assign params_out   = params_q;
  assign mu_out       = bar_out_q.mu;
  assign k_out        = bar_out_q.k;
  assign cfg_valid    = cfg_valid_q;

endmodule

// File: doc/curve_config_unit.md
Name: curve_config_unit

Overview:
- Runtime-programmable store for up to NUM_CURVES elliptic-curve parameter sets (p, n, a, b, base point).
- On commit, computes each slot's Barrett constants: k = bit length of p, and mu = floor(2^(2k)/p). It uses a sequential shift-subtract divider.
- Presents the selected slot's parameters and constants to the point-arithmetic and modular-multiplier datapath.
- Replaces the compile-time-only curve parameters and fixed Barrett constants.

Parameters:
- P_WIDTH, 256, field element width.
- NUM_CURVES, 4, number of parameter slots (>=1).
- ID_W, $clog2(NUM_CURVES) (min 1), derived slot index width.
- K_W, $clog2(P_WIDTH+1), derived width of k.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- wr_en  in  1  field write strobe
- wr_id  in  ID_W  target slot
- wr_field  in  3  0=p 1=n 2=a 3=b 4=gx 5=gy; 6,7 ignored
- wr_data  in  P_WIDTH  field value
- wr_err  out  1  1-cycle pulse: write rejected
- commit_valid  in  1  request constant computation
- commit_id  in  ID_W  slot to commit
- commit_ready  out  1  high in IDLE
- sel_id  in  ID_W  active slot select
- busy  out  1  computation in progress
- params_out  out  curve_parameters_t  registered parameters of sel_id
- mu_out  out  P_WIDTH+2  registered mu of sel_id
- k_out  out  K_W  registered k of sel_id
- cfg_valid  out  1  registered slot_valid[sel_id]
- commit_err  out  1  1-cycle pulse: commit failed (p<2)

Behaviour:
- Reset:
  - All slot fields, mu, k and slot_valid are cleared to 0.
  - FSM goes to IDLE; busy=0, commit_ready=1.
  - params_out, mu_out, k_out, cfg_valid, wr_err and commit_err are 0 the cycle after reset.
- Writes:
  - On wr_en, the field updates and slot_valid[wr_id] clears in the same edge.
  - Exception: if busy and wr_id equals the committing slot, the write is ignored and wr_err pulses next cycle.
- Commit handshake:
  - A commit is accepted when commit_valid && commit_ready.
  - The slot id and p are latched into working registers.
  - A commit request while busy is not accepted; the requester holds commit_valid.
- FSM: IDLE -> SCAN -> DIV -> DONE -> IDLE.
- SCAN (1 cycle):
  - A priority encoder sets k = index of MSB of p, plus 1.
  - If p<2: go to IDLE, pulse commit_err, and clear slot_valid for the slot.
- DIV (exactly 2k+1 cycles, one quotient bit per cycle, MSB first):
  - Dividend is 2^(2k).
  - Remainder register is P_WIDTH+1 bits; restoring compare-subtract.
  - Quotient register is P_WIDTH+2 bits.
  - Bound: mu <= 2^(k+1), with equality iff p = 2^(k-1).
- DONE (1 cycle): write mu and k to the slot and set slot_valid.
- Latency: busy is high for 2k+3 cycles starting the cycle after acceptance; commit_ready returns on the following edge.
- Outputs:
  - params_out, mu_out, k_out and cfg_valid are registered copies of the sel_id slot, with 1-cycle latency from a sel_id change or a slot update.
  - A write to the selected slot drops cfg_valid one cycle later.
- Simultaneous events:
  - A write and a DONE on the same slot in the same cycle cannot occur, because such writes are rejected.
  - A commit accepted in the same cycle as a write to that slot latches the pre-write p; slot_valid still clears and then sets at DONE.
  - Software must recommit after writing p.
- Reset mid-computation: aborts immediately, and all state is cleared as above.

Decomposition:
- Shared package, extending elliptic_curve_structs:
  - P_WIDTH, curve_point_t, curve_parameters_t.
  - A new barrett_params_t {mu [P_WIDTH+1:0], k [K_W-1:0]}, replacing the 1-bit barrett_constants_t.
  - A curve_field_e enum for wr_field encodings.
- Sub-module barrett_mu_divider: start/done handshake; inputs p and k; output mu; owns the DIV counter and remainder. The FSM wrapper keeps the slot storage and priority encoder.

Test Plan:
- P_WIDTH=6, slot 0 p=37, commit -> k=6, mu=110, busy high 15 cycles, cfg_valid=1 with sel_id=0.
- P_WIDTH=32, p=4294967291 -> k=32, mu=0x1_0000_0005, busy 67 cycles.
- P_WIDTH=6, p=32 -> k=6, mu=128; this boundary case uses the top quotient bit.
- Write p=1 then commit -> commit_err pulse, cfg_valid=0. Write during busy to the committing slot -> wr_err pulse and field unchanged. Write to another slot -> accepted.
- P_WIDTH=256 secp256k1 p -> k=256, mu=2^256+0x1000003D1. Assert reset at DIV cycle 100 -> all outputs 0, commit_ready=1 next cycle.
- Program slots 0 and 1 with different curves and toggle sel_id every cycle -> outputs track with 1-cycle latency; a write to slot 1 while it is selected drops cfg_valid next cycle.
